// File: rtl/spi_pkg.sv
// spi_pkg: constants and types shared by the SPI slave receiver.
//   SPI_DATA_W           default frame width; matches the 16-bit master.
//   CPOL_IDX / CPHA_IDX  bit positions inside the 2-bit spi_mode word.
//   SPI_MODE0..3         the four standard mode encodings.
//   spi_state_t          slave frame state machine encoding.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  localparam int CPOL_IDX = 1;
  localparam int CPHA_IDX = 0;

  localparam logic [1:0] SPI_MODE0 = 2'd0;  // CPOL=0, CPHA=0
  localparam logic [1:0] SPI_MODE1 = 2'd1;  // CPOL=0, CPHA=1
  localparam logic [1:0] SPI_MODE2 = 2'd2;  // CPOL=1, CPHA=0
  localparam logic [1:0] SPI_MODE3 = 2'd3;  // CPOL=1, CPHA=1

  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    SHIFT      = 2'd2,
    HOLD       = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer for an asynchronous input, with
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk    system clock
//   rst    synchronous, active-low reset (all stages load RST_VAL)
//   din    asynchronous input
//   sync   synchronized level (STAGES clk cycles behind din)
//   rise   one-cycle pulse when sync goes 0->1
//   fall   one-cycle pulse when sync goes 1->0
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= {STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign sync = sync_reg[STAGES-1];
  assign rise = sync & ~prev_reg;
  assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI slave, all four modes, MSB first.
// sclk, mosi and ss_n are synchronized into clk with equal depth, so mosi is
// sampled with the same delay as the sclk edge that qualifies it.
//   clk        system clock
//   rst        synchronous, active-low reset
//   spi_mode   [1]=CPOL [0]=CPHA, latched at frame start
//   ss_n       slave select, active low
//   sclk/mosi  SPI clock and data from the master
//   miso       reply bit, 0 while not selected
//   tx_data    reply word, latched at frame start
//   rx_data    last complete received word
//   rx_valid   one-cycle pulse when rx_data updates
//   busy       high in SHIFT or HOLD
//   frame_err  one-cycle pulse on a short or overrun frame
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        spi_mode,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // ---------------- input synchronization ----------------
  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .sync (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // ss_n resets to "selected" so a frame already in flight at reset release
  // is never mistaken for a fresh one; the FSM waits for a real deselect.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_n),
    .sync (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      mosi_sync_reg <= '0;
    end else begin
      mosi_sync_reg[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_sync_reg[i] <= mosi_sync_reg[i-1];
      end
    end
  end

  assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

  // ---------------- state ----------------
  spi_state_t        state_reg,     state_next;
  logic [1:0]        mode_reg,      mode_next;
  logic [DATA_W-1:0] tx_sr_reg,     tx_sr_next;
  logic [DATA_W-2:0] rx_sr_reg,     rx_sr_next;
  logic [CNT_W-1:0]  bit_cnt_reg,   bit_cnt_next;
  logic              first_reg,     first_next;
  logic              overrun_reg,   overrun_next;
  logic              miso_reg,      miso_next;
  logic [DATA_W-1:0] rx_data_reg,   rx_data_next;
  logic              rx_valid_reg,  rx_valid_next;
  logic              frame_err_reg, frame_err_next;

  // Leading edge leaves the CPOL idle level, trailing edge returns to it.
  logic sclk_edge, cpol, cpha, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [DATA_W-1:0] rx_shifted;

  assign sclk_edge   = sclk_rise | sclk_fall;
  assign cpol        = mode_reg[CPOL_IDX];
  assign cpha        = mode_reg[CPHA_IDX];
  assign lead_edge   = sclk_edge & (sclk_sync != cpol);
  assign trail_edge  = sclk_edge & (sclk_sync == cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge  : trail_edge;
  assign rx_shifted  = {rx_sr_reg, mosi_sync};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= WAIT_DESEL;
      mode_reg      <= '0;
      tx_sr_reg     <= '0;
      rx_sr_reg     <= '0;
      bit_cnt_reg   <= '0;
      first_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      tx_sr_reg     <= tx_sr_next;
      rx_sr_reg     <= rx_sr_next;
      bit_cnt_reg   <= bit_cnt_next;
      first_reg     <= first_next;
      overrun_reg   <= overrun_next;
      miso_reg      <= miso_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    tx_sr_next     = tx_sr_reg;
    rx_sr_next     = rx_sr_reg;
    bit_cnt_next   = bit_cnt_reg;
    first_next     = first_reg;
    overrun_next   = overrun_reg;
    miso_next      = miso_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;

    unique case (state_reg)
      WAIT_DESEL: begin
        miso_next = 1'b0;
        if (ss_sync) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        miso_next    = 1'b0;
        overrun_next = 1'b0;
        if (ss_fall) begin
          mode_next    = spi_mode;
          tx_sr_next   = tx_data;
          rx_sr_next   = '0;
          bit_cnt_next = '0;
          first_next   = 1'b1;
          // CPHA=0: the master samples on the first edge, so the MSB must
          // already be on the line; CPHA=1 drives it on the first edge.
          miso_next    = spi_mode[CPHA_IDX] ? 1'b0 : tx_data[DATA_W-1];
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        if (ss_rise) begin
          frame_err_next = 1'b1;
          miso_next      = 1'b0;
          state_next     = IDLE;
        end else begin
          if (shift_edge) begin
            if (cpha && first_reg) begin
              miso_next  = tx_sr_reg[DATA_W-1];
              first_next = 1'b0;
            end else begin
              tx_sr_next = {tx_sr_reg[DATA_W-2:0], 1'b0};
              miso_next  = tx_sr_reg[DATA_W-2];
            end
          end
          if (sample_edge) begin
            rx_sr_next   = rx_shifted[DATA_W-2:0];
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
              rx_data_next  = rx_shifted;
              rx_valid_next = 1'b1;
              miso_next     = 1'b0;
              state_next    = HOLD;
            end
          end
        end
      end

      HOLD: begin
        miso_next = 1'b0;
        if (ss_rise) begin
          frame_err_next = overrun_reg;
          overrun_next   = 1'b0;
          state_next     = IDLE;
        end else if (sample_edge) begin
          overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = WAIT_DESEL;
      end
    endcase
  end

  assign miso      = miso_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg == SHIFT) || (state_reg == HOLD);

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int HALF = 4;  // sclk half period in clk cycles

  logic        clk;
  logic        rst;
  logic [1:0]  spi_mode;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        frame_err;

  int checks;
  int errors;
  int rx_cnt;
  int ferr_cnt;
  int both_cnt;
  logic [15:0] rx_q[$];

  spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_mode  (spi_mode),
    .ss_n      (ss_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: outputs are registered at posedge, observed at negedge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt = rx_cnt + 1;
      rx_q.push_back(rx_data);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic clear_counts();
    rx_cnt   = 0;
    ferr_cnt = 0;
    rx_q.delete();
  endtask

  // Bus-master model. Optional hooks: assert reset at bit rst_bit, release it
  // at bit rel_bit, and change tx_data at bit txc_bit (-1 disables a hook).
  task automatic spi_frame(input logic [1:0] mode, input logic [15:0] din,
                           input int nbits, input int rst_bit, input int rel_bit,
                           input int txc_bit, input logic [15:0] txc_val,
                           output logic [15:0] dout, output logic busy_mid);
    logic cpol, cpha;
    cpol     = mode[1];
    cpha     = mode[0];
    spi_mode = mode;
    sclk     = cpol;
    dout     = '0;
    busy_mid = 1'b0;
    repeat (6) @(negedge clk);
    ss_n = 1'b0;
    mosi = cpha ? 1'b0 : din[15];
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) rst = 1'b0;
      if (i == rel_bit) rst = 1'b1;
      if (i == txc_bit) tx_data = txc_val;
      if (i == 4) busy_mid = busy;
      sclk = ~cpol;
      if (!cpha) begin
        if (i < 16) dout[15-i] = miso;
      end else begin
        mosi = (i < 16) ? din[15-i] : 1'b0;
      end
      repeat (HALF) @(negedge clk);
      sclk = cpol;
      if (!cpha) begin
        mosi = (i < 15) ? din[14-i] : 1'b0;
      end else if (i < 16) begin
        dout[15-i] = miso;
      end
      repeat (HALF) @(negedge clk);
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    $display("frame mode=%0d bits=%0d din=%h dout=%h rx_data=%h rx_valid_pulses=%0d frame_err_pulses=%0d",
             mode, nbits, din, dout, rx_data, rx_cnt, ferr_cnt);
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    ss_n     = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    spi_mode = SPI_MODE0;
    tx_data  = 16'h0000;
    repeat (5) @(negedge clk);
    checks++;
    if ({miso, rx_valid, busy, frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got miso/rx_valid/busy/frame_err=%b expected 0000",
               {miso, rx_valid, busy, frame_err});
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx_data: got %h expected 0000", rx_data);
    end
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_mode0();
    logic [15:0] dout;
    logic bm;
    clear_counts();
    tx_data = 16'hCAFE;
    spi_frame(SPI_MODE0, 16'h1234, 16, -1, -1, -1, 16'h0, dout, bm);
    checks++;
    if (dout !== 16'hCAFE) begin
      errors++;
      $display("FAIL mode0_dout: got %h expected CAFE", dout);
    end
    checks++;
    if (rx_cnt !== 1 || rx_data !== 16'h1234) begin
      errors++;
      $display("FAIL mode0_rx: got %0d pulses data %h expected 1 pulse data 1234", rx_cnt, rx_data);
    end
    checks++;
    if (ferr_cnt !== 0) begin
      errors++;
      $display("FAIL mode0_frame_err: got %0d pulses expected 0", ferr_cnt);
    end
    checks++;
    if (bm !== 1'b1) begin
      errors++;
      $display("FAIL mode0_busy_mid: got %b expected 1", bm);
    end
    checks++;
    if (busy !== 1'b0 || miso !== 1'b0) begin
      errors++;
      $display("FAIL mode0_deselected: got busy=%b miso=%b expected 0 0", busy, miso);
    end
  endtask

  task automatic test_short_frame();
    logic [15:0] dout;
    logic bm;
    clear_counts();
    spi_frame(SPI_MODE0, 16'hFFFF, 8, -1, -1, -1, 16'h0, dout, bm);
    checks++;
    if (ferr_cnt !== 1 || rx_cnt !== 0) begin
      errors++;
      $display("FAIL short_pulses: got frame_err=%0d rx_valid=%0d expected 1 0", ferr_cnt, rx_cnt);
    end
    checks++;
    if (rx_data !== 16'h1234) begin
      errors++;
      $display("FAIL short_rx_kept: got %h expected 1234", rx_data);
    end
    clear_counts();
    spi_frame(SPI_MODE0, 16'h3C5A, 16, -1, -1, -1, 16'h0, dout, bm);
    checks++;
    if (rx_cnt !== 1 || rx_data !== 16'h3C5A || ferr_cnt !== 0) begin
      errors++;
      $display("FAIL short_recover: got %0d pulses data %h err %0d expected 1 3C5A 0",
               rx_cnt, rx_data, ferr_cnt);
    end
  endtask

  task automatic test_modes();
    logic [15:0] dout;
    logic bm;
    logic [1:0] modes [3];
    modes[0] = SPI_MODE3;
    modes[1] = SPI_MODE1;
    modes[2] = SPI_MODE2;
    tx_data = 16'h5A3C;
    for (int m = 0; m < 3; m++) begin
      clear_counts();
      spi_frame(modes[m], 16'hA5C3, 16, -1, -1, -1, 16'h0, dout, bm);
      checks++;
      if (dout !== 16'h5A3C) begin
        errors++;
        $display("FAIL mode%0d_dout: got %h expected 5A3C", modes[m], dout);
      end
      checks++;
      if (rx_cnt !== 1 || rx_data !== 16'hA5C3 || ferr_cnt !== 0) begin
        errors++;
        $display("FAIL mode%0d_rx: got %0d pulses data %h err %0d expected 1 A5C3 0",
                 modes[m], rx_cnt, rx_data, ferr_cnt);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] dout;
    logic bm;
    clear_counts();
    tx_data = 16'h1357;
    spi_frame(SPI_MODE0, 16'hBEEF, 17, -1, -1, -1, 16'h0, dout, bm);
    checks++;
    if (rx_cnt !== 1 || rx_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL overrun_rx: got %0d pulses data %h expected 1 BEEF", rx_cnt, rx_data);
    end
    checks++;
    if (ferr_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_frame_err: got %0d pulses expected 1", ferr_cnt);
    end
    checks++;
    if (dout !== 16'h1357) begin
      errors++;
      $display("FAIL overrun_dout: got %h expected 1357", dout);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] dout;
    logic bm;
    clear_counts();
    spi_frame(SPI_MODE0, 16'hFACE, 16, 6, 9, -1, 16'h0, dout, bm);
    checks++;
    if (rx_cnt !== 0 || ferr_cnt !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses: got rx_valid=%0d frame_err=%0d expected 0 0", rx_cnt, ferr_cnt);
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_rx_cleared: got %h expected 0000", rx_data);
    end
    clear_counts();
    spi_frame(SPI_MODE0, 16'h0F0F, 16, -1, -1, -1, 16'h0, dout, bm);
    checks++;
    if (rx_cnt !== 1 || rx_data !== 16'h0F0F) begin
      errors++;
      $display("FAIL rstmid_next: got %0d pulses data %h expected 1 0F0F", rx_cnt, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d1, d2;
    logic bm;
    clear_counts();
    tx_data = 16'h1111;
    spi_frame(SPI_MODE0, 16'hAAAA, 16, -1, -1, 8, 16'h2222, d1, bm);
    spi_frame(SPI_MODE0, 16'h5555, 16, -1, -1, -1, 16'h0, d2, bm);
    checks++;
    if (d1 !== 16'h1111 || d2 !== 16'h2222) begin
      errors++;
      $display("FAIL b2b_dout: got %h %h expected 1111 2222", d1, d2);
    end
    checks++;
    if (rx_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses expected 2", rx_cnt);
    end else begin
      checks++;
      if (rx_q[0] !== 16'hAAAA || rx_q[1] !== 16'h5555) begin
        errors++;
        $display("FAIL b2b_rx: got %h %h expected AAAA 5555", rx_q[0], rx_q[1]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    both_cnt = 0;
    rx_cnt   = 0;
    ferr_cnt = 0;
    test_reset();
    test_mode0();
    test_short_frame();
    test_modes();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses: got %0d cycles with rx_valid and frame_err expected 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Oversampling SPI slave endpoint on the far side of the bus driven by the 16-bit `spi_updated` master.
- Consumes the master's sclk, mosi and one ss line; returns miso. All logic runs in the single system clock domain.
- Delivers each received 16-bit word to local logic with a one-cycle valid pulse, and shifts out a locally supplied reply word.
- Supports all four SPI modes, MSB first, matching the master's 16-bit frame.

Parameters:
- DATA_W, 16, frame length in bits; must equal the master's frame width.
- SYNC_STAGES, 2, flip-flop stages on sclk, mosi and ss_n before any use.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- spi_mode  in  2  [1]=CPOL, [0]=CPHA; sampled at frame start.
- ss_n  in  1  slave select from the master's ss bus, active low.
- sclk  in  1  SPI clock from the master (asynchronous to clk).
- mosi  in  1  serial data from the master.
- miso  out  1  serial reply; driven 0 when not selected.
- tx_data  in  DATA_W  reply word; captured at frame start.
- rx_data  out  DATA_W  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high while in SHIFT or HOLD.
- frame_err  out  1  one-cycle pulse on a short or overrun frame.

Behaviour:
- Reset values (rst=0 at a clk edge):
  - miso=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, bit count=0.
  - ss_n synchronizer resets to 0 (selected). sclk/mosi synchronizers reset to 0.
  - State resets to WAIT_DESEL.
- Edge detection:
  - Operates on the synchronized sclk; prev-sclk register updates every cycle.
  - Leading edge = transition away from CPOL level; trailing edge = transition back.
  - CPHA=0: sample mosi on leading edge, shift miso on trailing edge. CPHA=1: the reverse.
  - Synchronized mosi is used, aligned with sclk, so sample and clock delays are equal.
- Timing constraint: sclk high and low times ≥ SYNC_STAGES+2 clk cycles. Compliant with the master at N≥4.
- WAIT_DESEL: ignore sclk; go to IDLE when synced ss_n=1. This guarantees no partial frame is accepted after reset or mid-frame reset release.
- IDLE: on synced ss_n 1→0:
  - latch spi_mode and tx_data into the tx shift register; clear bit count; go to SHIFT.
  - CPHA=0: miso=tx MSB in the same cycle as the SHIFT entry.
- SHIFT:
  - On each sample edge: rx shift register <= {rx[DATA_W-2:0], mosi}; count++.
  - On each shift edge: tx shift left, miso=new MSB. For CPHA=1 the first leading edge drives the MSB and does not shift.
  - On the DATA_W-th sample edge: rx_data <= completed word and rx_valid=1 in the next cycle. Latency is SYNC_STAGES+1 cycles from the pin edge. Go to HOLD.
  - ss_n→1 before DATA_W samples: frame_err pulse, rx_data unchanged, no rx_valid, go to IDLE.
- HOLD:
  - Further sample edges set the overrun flag; data is discarded and miso=0.
  - ss_n→1: go to IDLE; pulse frame_err if overrun, then clear the overrun flag.
- Deselected (IDLE, WAIT_DESEL): miso=0, busy=0.
- spi_mode or tx_data changes mid-frame have no effect until the next frame.
- Reset mid-frame: clear as above; rx_valid must not pulse for the aborted frame.
- rx_valid and frame_err are never high in the same cycle.

Decomposition:
- Package spi_pkg:
  - DATA_W default.
  - CPOL/CPHA bit index constants and the mode encodings 0–3.
  - State enum: WAIT_DESEL, IDLE, SHIFT, HOLD.
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchronizer with parameterized reset value, plus rise/fall pulse outputs. Instantiated for sclk and ss_n; mosi uses the synchronizer only.

Test Plan:
1. Mode 0, master N=4, din=16'h1234, tx_data=16'hCAFE → exactly one rx_valid pulse with rx_data=16'h1234; master dout=16'hCAFE; frame_err never pulses.
2. Mode 3, din=16'hA5C3, tx_data=16'h5A3C → rx_data=16'hA5C3, master dout=16'h5A3C. Repeat for modes 1 and 2 with the same values.
3. Short frame: 8 sclk periods then ss_n→1 → frame_err pulses once, no rx_valid, rx_data keeps 16'h1234. Next full frame is received correctly.
4. Overrun: 17 sample edges, first 16 bits = 16'hBEEF → rx_valid once with 16'hBEEF; frame_err pulses after ss_n→1.
5. Reset asserted at bit 6 with ss_n held low, released at bit 9 → no rx_valid or frame_err for that frame. After ss_n→1 and a new frame with 16'h0F0F → rx_data=16'h0F0F.
6. Back-to-back frames: tx_data changed from 16'h1111 to 16'h2222 mid-first-frame → master receives 16'h1111 then 16'h2222; two rx_valid pulses.
